// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write-port arbiter for the working-register bank: two requesters share one
// registered write path, with per-requester ack pulses, a grant hold and a conflict counter.
module reg_bank_wr_arbiter #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            hold,
    input  logic            req0,
    input  logic [AW-1:0]   addr0,
    input  logic [7:0]      data0,
    input  logic            req1,
    input  logic [AW-1:0]   addr1,
    input  logic [7:0]      data1,
    output logic            ack0,
    output logic            ack1,
    output logic [NREG-1:0] wr_en,
    output logic [7:0]      wr_data,
    output logic            addr_err,
    output logic [7:0]      conflict_cnt
);

    localparam logic [AW:0] NregLim = (AW + 1)'(NREG);

    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic [NREG-1:0] wr_en_q, wr_en_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            addr_err_q, addr_err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            rr_q, rr_d;

    logic            elig0, elig1;
    logic            grant, win;
    logic [AW-1:0]   waddr;

    always_comb begin
        // A live ack masks its requester so a still-high req is not granted twice.
        elig0      = req0 & ~ack0_q;
        elig1      = req1 & ~ack1_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        wr_en_d    = '0;
        addr_err_d = 1'b0;
        wr_data_d  = wr_data_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        grant      = 1'b0;
        win        = 1'b0;
        waddr      = '0;

        if (!hold && (elig0 || elig1)) begin
            grant = 1'b1;
            if (elig0 && elig1) begin
                win = rr_q;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                win = elig1;
            end
            rr_d = ~win;
        end

        if (grant) begin
            waddr     = win ? addr1 : addr0;
            wr_data_d = win ? data1 : data0;
            ack0_d    = ~win;
            ack1_d    = win;
            if ({1'b0, waddr} < NregLim) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    wr_en_d[i] = (waddr == AW'(i));
                end
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_en_q    <= '0;
            wr_data_q  <= 8'h00;
            addr_err_q <= 1'b0;
            cnt_q      <= 8'h00;
            rr_q       <= 1'b0;
        end else begin
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign addr_err     = addr_err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Bench for reg_bank_wr_arbiter: directed stimulus pushes expected grants into a queue that a
// negedge monitor drains; a behavioural register bank (reset to FFh) checks the write path.
module tb_reg_bank_wr_arbiter;

    localparam int unsigned NREG = 6;
    localparam int unsigned AW   = 3;

    typedef struct packed {
        logic            ack0;
        logic            ack1;
        logic [NREG-1:0] wr_en;
        logic [7:0]      wr_data;
        logic            addr_err;
    } exp_t;

    logic            clock;
    logic            reset = 1'b1;
    logic            hold;
    logic            req0, req1;
    logic [AW-1:0]   addr0, addr1;
    logic [7:0]      data0, data1;
    logic            ack0, ack1;
    logic [NREG-1:0] wr_en;
    logic [7:0]      wr_data;
    logic            addr_err;
    logic [7:0]      conflict_cnt;

    logic [7:0]      bank [NREG];
    exp_t            exp_q [$];
    int              total = 0;
    int              bad   = 0;

    reg_bank_wr_arbiter #(
        .NREG(NREG),
        .AW  (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hold        (hold),
        .req0        (req0),
        .addr0       (addr0),
        .data0       (data0),
        .req1        (req1),
        .addr1       (addr1),
        .data1       (data1),
        .ack0        (ack0),
        .ack1        (ack1),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .addr_err    (addr_err),
        .conflict_cnt(conflict_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural register bank fed by the arbiter.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) bank[i] <= 8'hFF;
        end else begin
            for (int i = 0; i < NREG; i++) if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic a0, input logic a1, input logic [NREG-1:0] we,
                        input logic [7:0] d, input logic err);
        exp_t e;
        e.ack0 = a0;
        e.ack1 = a1;
        e.wr_en = we;
        e.wr_data = d;
        e.addr_err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented grant must match the next expected one, in order.
    always @(negedge clock) begin
        exp_t got, want;
        if (reset && (ack0 || ack1 || addr_err || wr_en != '0)) begin
            got = '{ack0: ack0, ack1: ack1, wr_en: wr_en, wr_data: wr_data, addr_err: addr_err};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant: unexpected output %0h, expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL grant: got %0h, expected %0h", got, want);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        data0 = 8'h00;
        data1 = 8'h00;
        #2;
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_cnt", 32'(conflict_cnt), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Idle after reset
        repeat (5) @(posedge clock);
        #1;
        check("idle_wr_en", 32'(wr_en), 0);
        check("idle_acks", 32'({ack0, ack1}), 0);
        check("idle_wr_data", 32'(wr_data), 0);
        check("idle_cnt", 32'(conflict_cnt), 0);

        // Single write: reg 3 <= 5Ah
        addr0 = 3'd3;
        data0 = 8'h5A;
        req0  = 1'b1;
        push(1'b1, 1'b0, 6'b001000, 8'h5A, 1'b0);
        @(posedge clock);
        #1;
        check("single_ack0", 32'(ack0), 1);
        check("single_wr_en", 32'(wr_en), 32'b001000);
        req0 = 1'b0;
        @(posedge clock);
        #1;
        check("single_ack0_low", 32'(ack0), 0);
        check("single_bank3", 32'(bank[3]), 32'h5A);

        // Round-robin from a fresh reset
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        addr0 = 3'd1;
        data0 = 8'h11;
        addr1 = 3'd2;
        data1 = 8'h22;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(1'b1, 1'b0, 6'b000010, 8'h11, 1'b0);
            push(1'b0, 1'b1, 6'b000100, 8'h22, 1'b0);
        end
        repeat (4) @(posedge clock);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_cnt", 32'(conflict_cnt), 1);
        @(posedge clock);
        #1;

        // Repeated fresh conflicts drive the counter into saturation
        for (int n = 1; n <= 300; n++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            push(1'b1, 1'b0, 6'b000010, 8'h11, 1'b0);
            push(1'b0, 1'b1, 6'b000100, 8'h22, 1'b0);
            repeat (2) @(posedge clock);
            #1;
            req0 = 1'b0;
            req1 = 1'b0;
            @(posedge clock);
            #1;
            if (n == 100) check("sat_cnt_101", 32'(conflict_cnt), 101);
            if (n == 254) check("sat_cnt_255", 32'(conflict_cnt), 255);
        end
        check("sat_cnt_final", 32'(conflict_cnt), 32'hFF);

        // Hold blocks grants, release grants on the next edge
        hold  = 1'b1;
        addr1 = 3'd4;
        data1 = 8'h44;
        req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check("hold_ack1", 32'(ack1), 0);
            check("hold_wr_en", 32'(wr_en), 0);
        end
        hold = 1'b0;
        push(1'b0, 1'b1, 6'b010000, 8'h44, 1'b0);
        @(posedge clock);
        #1;
        check("release_ack1", 32'(ack1), 1);

        // New request in the ack cycle, to an out-of-range register
        addr1 = 3'd7;
        data1 = 8'h77;
        push(1'b0, 1'b1, 6'b000000, 8'h77, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("bad_addr_err", 32'(addr_err), 1);
        check("bad_wr_en", 32'(wr_en), 0);
        req1 = 1'b0;
        @(posedge clock);
        #1;
        check("bank0", 32'(bank[0]), 32'hFF);
        check("bank1", 32'(bank[1]), 32'h11);
        check("bank2", 32'(bank[2]), 32'h22);
        check("bank3", 32'(bank[3]), 32'hFF);
        check("bank4", 32'(bank[4]), 32'h44);
        check("bank5", 32'(bank[5]), 32'hFF);

        // Reset lands between grant and bank capture
        addr0 = 3'd0;
        data0 = 8'h33;
        req0  = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_ack0_pre", 32'(ack0), 1);
        check("midrst_wr_en_pre", 32'(wr_en), 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_ack0", 32'(ack0), 0);
        check("midrst_wr_en", 32'(wr_en), 0);
        req0 = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_bank0", 32'(bank[0]), 32'hFF);
        check("midrst_wr_en_after", 32'(wr_en), 0);

        repeat (2) @(posedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_wr_arbiter.md
Name: reg_bank_wr_arbiter

Overview:
Write-port arbiter for a bank of NREG 8-bit reset-to-FFh working registers in the structural PIC datapath. Two requesters share the bank's single write path: requester 0 is core writeback, requester 1 is the peripheral/debug bus. The block selects one winner per cycle by round-robin and drives a registered one-hot write enable plus write data into the bank. Each requester gets a one-cycle ack. A hold input freezes grants while the core is stalled.

Parameters:
NREG, 8, number of 8-bit registers in the bank (2..16)
AW, 3, address width; must satisfy 2^AW >= NREG

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
hold  in  1  1 = no new grants this cycle
req0  in  1  requester 0 write request
addr0  in  AW  requester 0 target register
data0  in  8  requester 0 write data
req1  in  1  requester 1 write request
addr1  in  AW  requester 1 target register
data1  in  8  requester 1 write data
ack0  out  1  one-cycle grant pulse, requester 0
ack1  out  1  one-cycle grant pulse, requester 1
wr_en  out  NREG  one-hot write enables to the bank
wr_data  out  8  data to the bank
addr_err  out  1  one-cycle pulse: granted address >= NREG
conflict_cnt  out  8  saturating count of cycles in which both requesters were eligible

Behaviour:
- Reset (reset=0, asynchronous):
  - ack0, ack1, wr_en, addr_err and conflict_cnt are 0.
  - wr_data is 8'h00.
  - The rr pointer is 0, so requester 0 wins the first conflict.
  - All outputs are registered; no combinational path from inputs to outputs.
- Eligibility, evaluated at each rising edge:
  - Requester i is eligible if req_i=1 and ack_i=0 in the current cycle. The ack masks the cycle after a grant, which prevents a double grant when req is still high.
  - Consequence: one requester alone gets at most one write every 2 cycles. Alternating requesters can write on every cycle.
- Grant decision at edge E, applied only when hold=0:
  - No eligible requester: all pulses are 0 next cycle. wr_data holds its last value.
  - One eligible requester: that requester wins.
  - Both eligible: the requester selected by the rr pointer wins, and conflict_cnt increments, saturating at 8'hFF.
  - After any grant, the rr pointer moves to the other requester (pointer = ~winner).
  - Effects at E for winner w: ack_w=1 and wr_data=data_w.
    - If addr_w < NREG: wr_en[addr_w]=1.
    - Otherwise: wr_en is all 0 and addr_err=1.
  - All of these are high for exactly one cycle.
- Write timing:
  - The bank captures wr_data at edge E+1, so the write is visible on the register output after E+1.
  - Latency from a sampled req to the register update is 2 edges.
- Handshake:
  - The requester holds req, addr and data stable until it sees ack.
  - It may drop req or present a new request in the ack cycle; that new request becomes eligible at E+2.
  - Dropping req before ack is allowed (request withdrawn); nothing is written.
- hold=1 at an edge:
  - No grant, and conflict_cnt does not count.
  - The rr pointer is unchanged.
  - Outputs granted on the previous edge still complete their single pulse.
- Reset asserted mid-operation:
  - Any pending wr_en/ack pulse is cleared immediately.
  - No write reaches the bank after reset asserts; the bank itself resets to FFh.
- wr_en is never more than one-hot. ack0 and ack1 are never high together.

Test Plan:
- Reset then idle: after reset release with req0=req1=0 for 5 cycles -> wr_en=0, acks=0, wr_data=00h, conflict_cnt=0.
- Single write: req0=1, addr0=3, data0=5Ah at edge E -> ack0=1 and wr_en=8'b0000_1000 with wr_data=5Ah during E..E+1; register 3 reads 5Ah after E+1; ack0 low at E+1.
- Conflict round-robin:
  - Stimulus: from reset, req0 and req1 held high continuously, addr0=1/data0=11h, addr1=2/data1=22h.
  - Grants alternate 0,1,0,1 on consecutive edges; each ack pulses every other cycle.
  - conflict_cnt counts only the first edge: after that, one requester is always ack-masked.
- Repeated conflict saturation: re-assert req0 and req1 together at a fresh edge after both acks are low, for 300 occurrences -> conflict_cnt=FFh and stays there.
- Hold and bad address:
  - hold=1 with req1=1 for 4 cycles -> no ack, wr_en=0.
  - Release hold -> ack1 on the next edge.
  - addr1=7 with NREG=6 -> ack1=1, addr_err=1, wr_en=0, no register changes.
- Reset mid-write: assert reset between edge E and E+1 of a granted write (data0=33h to reg 0) -> wr_en and ack0 drop immediately; register 0 reads FFh after release.
